data_mem_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 18 +
 rtl/data_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU data-memory controller.
// Holds the command opcode encoding and the controller state enum.
package cpu_pkg;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_STORE    = 2'b01;
  localparam logic [1:0] OP_FILL     = 2'b10;
  localparam logic [1:0] OP_CHECKSUM = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_SAMPLE,
    RESP
  } state_e;

endpackage

// File: rtl/data_mem_ctrl.sv
// Initiator-side controller for data_memory.
// Turns LOAD/STORE/FILL/CHECKSUM commands into we/addr/data_in sequences,
// samples data_out on a two-cycle read, and returns one response per command.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op/cmd_addr/cmd_data/cmd_len command payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_data/rsp_ovf                response payload
//   mem_we/mem_addr/mem_wdata       drive data_memory inputs
//   mem_rdata                       data_memory read data
module data_mem_ctrl #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  input  logic [AW-1:0] cmd_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_ovf,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  import cpu_pkg::*;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_ovf_q, rsp_ovf_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cmd_ready_q, rsp_valid_q, mem_we_q;
  logic [DW:0]   sum;

  // Next-state, datapath and response computation.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    mem_wdata_d = mem_wdata_q;
    // Extra top bit captures the carry-out of the checksum add.
    sum         = {1'b0, acc_q} + {1'b0, mem_rdata};

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          data_d = cmd_data;
          cnt_d  = (cmd_op == OP_FILL || cmd_op == OP_CHECKSUM) ? cmd_len : '0;
          acc_d  = '0;
          ovf_d  = 1'b0;
          state_d = (cmd_op == OP_STORE || cmd_op == OP_FILL) ? WR : RD;
        end
      end
      WR: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          rsp_data_d = data_q;
          rsp_ovf_d  = 1'b0;
        end else begin
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - AW'(1);
        end
      end
      RD: begin
        state_d = RD_SAMPLE;
      end
      RD_SAMPLE: begin
        if (op_q == OP_CHECKSUM) begin
          acc_d = sum[DW-1:0];
          ovf_d = ovf_q | sum[DW];
        end
        if (cnt_q == '0) begin
          state_d = RESP;
          if (op_q == OP_CHECKSUM) begin
            rsp_data_d = sum[DW-1:0];
            rsp_ovf_d  = ovf_q | sum[DW];
          end else begin
            rsp_data_d = mem_rdata;
            rsp_ovf_d  = 1'b0;
          end
        end else begin
          addr_d  = addr_q + AW'(1);
          cnt_d   = cnt_q - AW'(1);
          state_d = RD;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Write data only moves when a write cycle is coming; otherwise it holds.
    if (state_d == WR) mem_wdata_d = data_d;
  end

  // State and datapath registers; flag outputs are pre-decoded from state_d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_LOAD;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      mem_wdata_q <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      mem_wdata_q <= mem_wdata_d;
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      mem_we_q    <= (state_d == WR);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with a behavioural data_memory model
// (combinational read, write on rising edge).
module tb_data_mem_ctrl;
  import cpu_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [AW-1:0] cmd_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_ovf;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  data_mem_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // data_memory model; initial content is word i = (3*i + 1) mod 16.
  logic [DW-1:0] mem [2**AW];
  logic          init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= DW'(i * 3 + 1);
      init_done <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Write log captured away from the clock edge.
  int wl_cyc[$];
  int wl_addr[$];
  int wl_data[$];
  always @(negedge clk) begin
    if (mem_we) begin
      wl_cyc.push_back(cyc);
      wl_addr.push_back(int'(mem_addr));
      wl_data.push_back(int'(mem_wdata));
    end
  end

  task automatic clear_log();
    wl_cyc.delete();
    wl_addr.delete();
    wl_data.delete();
  endtask

  // Scoreboard of expected responses.
  typedef struct packed {
    logic [DW-1:0] d;
    logic          ovf;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int d, input int ovf);
    exp_t x;
    x.d   = DW'(d);
    x.ovf = 1'(ovf);
    sb.push_back(x);
  endtask

  // Monitor: every response handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("rsp_data", int'(rsp_data), int'(x.d));
        check("rsp_ovf", int'(rsp_ovf), int'(x.ovf));
      end
    end
  end

  task automatic drive_cmd(input logic [1:0] op, input int a, input int d, input int l);
    cmd_op    = op;
    cmd_addr  = AW'(a);
    cmd_data  = DW'(d);
    cmd_len   = AW'(l);
    cmd_valid = 1'b1;
  endtask

  // Returns the cycle stamp just after the accepting edge.
  task automatic accept(output int e);
    @(negedge clk);
    for (int k = 0; k < 100 && !cmd_ready; k++) @(negedge clk);
    if (!cmd_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    e = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int e, input int lat, input string name);
    for (int k = 0; k < 200 && !rsp_valid; k++) @(negedge clk);
    if (!rsp_valid) check({name, "_timeout"}, 0, 1);
    else            check({name, "_latency"}, cyc - e, lat);
  endtask

  task automatic finish_rsp();
    for (int k = 0; k < 200 && !(rsp_valid && rsp_ready); k++) @(negedge clk);
    if (!(rsp_valid && rsp_ready)) check("handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input int a, input int d, input int l,
                        input int exp_d, input int exp_ovf, input int lat,
                        input string name);
    int e;
    push_exp(exp_d, exp_ovf);
    drive_cmd(op, a, d, l);
    accept(e);
    wait_rsp(e, lat, name);
    finish_rsp();
  endtask

  task automatic check_reset(input string p);
    check({p, "_cmd_ready"}, int'(cmd_ready), 1);
    check({p, "_rsp_valid"}, int'(rsp_valid), 0);
    check({p, "_rsp_data"},  int'(rsp_data), 0);
    check({p, "_rsp_ovf"},   int'(rsp_ovf), 0);
    check({p, "_mem_we"},    int'(mem_we), 0);
    check({p, "_mem_addr"},  int'(mem_addr), 0);
    check({p, "_mem_wdata"}, int'(mem_wdata), 0);
  endtask

  initial begin
    int e;
    int fa[3];
    fa = '{14, 15, 0};
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_LOAD;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_len   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Untouched word after reset: initial content, no writes.
    clear_log();
    do_cmd(OP_LOAD, 1, 0, 0, 4, 0, 2, "load1");
    check("load1_no_we", wl_cyc.size(), 0);

    // Single store produces exactly one write cycle.
    clear_log();
    do_cmd(OP_STORE, 5, 7, 0, 7, 0, 1, "store5");
    check("store5_we_count", wl_cyc.size(), 1);
    check("store5_we_addr", wl_addr[0], 5);
    check("store5_we_data", wl_data[0], 7);
    do_cmd(OP_LOAD, 5, 0, 0, 7, 0, 2, "load5a");

    // Overwrite.
    do_cmd(OP_STORE, 5, 12, 0, 12, 0, 1, "store5b");
    do_cmd(OP_LOAD, 5, 0, 0, 12, 0, 2, "load5b");

    // Fill with address wrap 14, 15, 0.
    clear_log();
    do_cmd(OP_FILL, 14, 9, 2, 9, 0, 3, "fill");
    check("fill_we_count", wl_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("fill_we_addr", wl_addr[i], fa[i]);
      check("fill_we_data", wl_data[i], 9);
      check("fill_we_consecutive", wl_cyc[i] - wl_cyc[0], i);
    end
    do_cmd(OP_LOAD, 14, 0, 0, 9, 0, 2, "load14");
    do_cmd(OP_LOAD, 15, 0, 0, 9, 0, 2, "load15");
    do_cmd(OP_LOAD, 0, 0, 0, 9, 0, 2, "load0");

    // 9+9+9 = 27 -> 11 with carry; single-word checksum has none.
    do_cmd(OP_CHECKSUM, 14, 0, 2, 11, 1, 6, "csum3");
    do_cmd(OP_CHECKSUM, 5, 0, 0, 12, 0, 2, "csum1");

    // Backpressure: response held, a second command waits.
    rsp_ready = 1'b0;
    push_exp(6, 0);
    drive_cmd(OP_STORE, 3, 6, 0);
    accept(e);
    wait_rsp(e, 1, "bp_store");
    push_exp(6, 0);
    drive_cmd(OP_LOAD, 3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", int'(rsp_valid), 1);
      check("bp_rsp_data", int'(rsp_data), 6);
      check("bp_cmd_ready", int'(cmd_ready), 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_after_hs", int'(cmd_ready), 1);
    check("bp_valid_after_hs", int'(rsp_valid), 0);
    @(posedge clk);
    #1;
    e = cyc;
    cmd_valid = 1'b0;
    check("bp_accepted", int'(cmd_ready), 0);
    check("bp_load_addr", int'(mem_addr), 3);
    wait_rsp(e, 2, "bp_load");
    finish_rsp();

    // Reset mid-fill, just after the words at 0 and 1 are committed.
    drive_cmd(OP_FILL, 0, 10, 7);
    accept(e);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_pre_we", int'(mem_we), 1);
    check("rst_pre_addr", int'(mem_addr), 2);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_cmd(OP_LOAD, 0, 0, 0, 10, 0, 2, "rst_load0");
    do_cmd(OP_LOAD, 1, 0, 0, 10, 0, 2, "rst_load1");
    do_cmd(OP_LOAD, 2, 0, 0, 7, 0, 2, "rst_load2");
    do_cmd(OP_LOAD, 7, 0, 0, 6, 0, 2, "rst_load7");

    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
